// File: rtl/instruction_fetch_if.sv
// Instruction-fetch bus bundle: instruction-memory read port, redirect
// request from execute, the IF/ID valid/ready handoff to decode, and the
// fault/statistics outputs.
// The master modport is the fetch unit. The slave modport is everything
// around it: memory, branch unit and decode.
interface instruction_fetch_if #(
  parameter int INSTRUCTION_WIDTH = 32
);
  // Instruction memory read port.
  logic [INSTRUCTION_WIDTH-1:0] imem_read_addr;
  logic [INSTRUCTION_WIDTH-1:0] imem_instruction;

  // Branch/jump redirect request.
  logic                         redirect_valid;
  logic [INSTRUCTION_WIDTH-1:0] redirect_addr;

  // IF/ID handoff to decode.
  logic                         if_valid;
  logic                         if_ready;
  logic [INSTRUCTION_WIDTH-1:0] if_instruction;
  logic [INSTRUCTION_WIDTH-1:0] if_pc;

  // Misaligned-target trap and accepted-transfer counter.
  logic                         misaligned_fault;
  logic [INSTRUCTION_WIDTH-1:0] fault_addr;
  logic [INSTRUCTION_WIDTH-1:0] fetch_count;

  modport master (
    output imem_read_addr,
    input  imem_instruction,
    input  redirect_valid,
    input  redirect_addr,
    output if_valid,
    input  if_ready,
    output if_instruction,
    output if_pc,
    output misaligned_fault,
    output fault_addr,
    output fetch_count
  );

  modport slave (
    input  imem_read_addr,
    output imem_instruction,
    output redirect_valid,
    output redirect_addr,
    input  if_valid,
    output if_ready,
    input  if_instruction,
    input  if_pc,
    input  misaligned_fault,
    input  fault_addr,
    input  fetch_count
  );

endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage. Owns the PC and drives the memory address straight
// from the PC register. Each returned word is captured into the IF/ID register
// and offered to decode with valid/ready.
// An aligned redirect flushes the held word and reloads the PC. A misaligned
// redirect parks the unit in FAULT until reset.
module instruction_fetch #(
  parameter int                           INSTRUCTION_WIDTH = 32,
  parameter logic [INSTRUCTION_WIDTH-1:0] RESET_PC          = '0
) (
  input logic                 clk,
  input logic                 rst,
  instruction_fetch_if.master bus
);

  localparam logic [INSTRUCTION_WIDTH-1:0] PC_STEP    = INSTRUCTION_WIDTH'(4);
  localparam logic [INSTRUCTION_WIDTH-1:0] COUNT_STEP = INSTRUCTION_WIDTH'(1);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [INSTRUCTION_WIDTH-1:0] pc_reg;
  logic [INSTRUCTION_WIDTH-1:0] pc_next;
  logic                         valid_reg;
  logic                         valid_next;
  logic [INSTRUCTION_WIDTH-1:0] instr_reg;
  logic [INSTRUCTION_WIDTH-1:0] instr_next;
  logic [INSTRUCTION_WIDTH-1:0] if_pc_reg;
  logic [INSTRUCTION_WIDTH-1:0] if_pc_next;
  logic                         fault_reg;
  logic                         fault_next;
  logic [INSTRUCTION_WIDTH-1:0] fault_addr_reg;
  logic [INSTRUCTION_WIDTH-1:0] fault_addr_next;
  logic [INSTRUCTION_WIDTH-1:0] count_reg;
  logic [INSTRUCTION_WIDTH-1:0] count_next;

  // Request decode, used only while in RUN.
  logic redirect_misaligned;
  logic redirect_aligned;
  logic load_word;
  logic accept;

  // A redirect target is misaligned when either of its two low bits is set.
  assign redirect_misaligned = bus.redirect_valid && (bus.redirect_addr[1:0] != 2'b00);
  assign redirect_aligned    = bus.redirect_valid && (bus.redirect_addr[1:0] == 2'b00);

  // The IF/ID slot can take a new word when it is empty or being drained.
  assign load_word = !bus.redirect_valid && (!valid_reg || bus.if_ready);

  // A transfer to decode only counts when no redirect flushes it the same edge.
  assign accept = (state_reg == RUN) && valid_reg && bus.if_ready && !bus.redirect_valid;

  // State register: RUN after reset, FAULT is sticky until the next reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: only a misaligned redirect seen in RUN leaves RUN.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN: begin
        if (redirect_misaligned) begin
          state_next = FAULT;
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = state_reg;
      end
    endcase
  end

  // Datapath next values, in priority order: fault trap, aligned redirect
  // (flush), fetch/advance, stall.
  always_comb begin
    pc_next         = pc_reg;
    valid_next      = valid_reg;
    instr_next      = instr_reg;
    if_pc_next      = if_pc_reg;
    fault_next      = fault_reg;
    fault_addr_next = fault_addr_reg;
    count_next      = count_reg;

    if (state_reg == RUN) begin
      if (redirect_misaligned) begin
        // Trap. The PC stays where it was so the fault address is the only
        // record of the bad target.
        fault_next      = 1'b1;
        fault_addr_next = bus.redirect_addr;
        valid_next      = 1'b0;
      end else if (redirect_aligned) begin
        // Flush the held word, even if decode is taking it this edge.
        pc_next    = bus.redirect_addr;
        valid_next = 1'b0;
      end else if (load_word) begin
        instr_next = bus.imem_instruction;
        if_pc_next = pc_reg;
        valid_next = 1'b1;
        pc_next    = pc_reg + PC_STEP;
      end
      // Otherwise decode is stalling a live word: hold everything.

      if (accept) begin
        count_next = count_reg + COUNT_STEP;
      end
    end else begin
      // FAULT: nothing is offered to decode and redirects are ignored.
      valid_next = 1'b0;
    end
  end

  // PC, IF/ID register, fault capture and transfer counter, all cleared by
  // the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg         <= RESET_PC;
      valid_reg      <= 1'b0;
      instr_reg      <= '0;
      if_pc_reg      <= '0;
      fault_reg      <= 1'b0;
      fault_addr_reg <= '0;
      count_reg      <= '0;
    end else begin
      pc_reg         <= pc_next;
      valid_reg      <= valid_next;
      instr_reg      <= instr_next;
      if_pc_reg      <= if_pc_next;
      fault_reg      <= fault_next;
      fault_addr_reg <= fault_addr_next;
      count_reg      <= count_next;
    end
  end

  // Memory address comes straight from the PC register, with no combinational
  // path from the inputs.
  assign bus.imem_read_addr   = pc_reg;
  assign bus.if_valid         = valid_reg;
  assign bus.if_instruction   = instr_reg;
  assign bus.if_pc            = if_pc_reg;
  assign bus.misaligned_fault = fault_reg;
  assign bus.fault_addr       = fault_addr_reg;
  assign bus.fetch_count      = count_reg;

  // The PC must stay word aligned (aligned reset value, aligned redirects only).
  a_pc_aligned : assert property (
    @(posedge clk) disable iff (rst) pc_reg[1:0] == 2'b00
  );

  // A word held for a stalled decode must not change under it.
  a_hold_stable : assert property (
    @(posedge clk) disable iff (rst)
      (valid_reg && !bus.if_ready) |=> ($stable(instr_reg) && $stable(if_pc_reg))
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch. A transaction-level model predicts the outputs,
// and one per-cycle compare task checks the DUT against it. Literal checks pin
// the directed scenarios.
// A second instance with RESET_PC = FFFF_FFFC exercises PC wrap.
module tb_instruction_fetch;

  localparam int          W       = 32;
  localparam logic [31:0] MAIN_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  logic rst;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instruction_fetch_if #(.INSTRUCTION_WIDTH(W)) bus  ();
  instruction_fetch_if #(.INSTRUCTION_WIDTH(W)) bus2 ();

  instruction_fetch #(.INSTRUCTION_WIDTH(W), .RESET_PC(MAIN_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  instruction_fetch #(.INSTRUCTION_WIDTH(W), .RESET_PC(WRAP_PC)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus2.master)
  );

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    if (a == 32'h4) return 32'h0050_0093;
    return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_instruction  = mem_word(bus.imem_read_addr);
  assign bus2.imem_instruction = mem_word(bus2.imem_read_addr);
  assign bus2.if_ready         = 1'b1;
  assign bus2.redirect_valid   = 1'b0;
  assign bus2.redirect_addr    = '0;

  // Reference model state for the main instance.
  logic [31:0] m_pc, m_instr, m_ipc, m_faddr, m_count;
  logic        m_valid, m_fault, m_xfer;

  // Reference model state for the wrap instance.
  logic [31:0] m2_pc, m2_ipc;
  logic        m2_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc     = MAIN_PC;
    m_valid  = 1'b0;
    m_instr  = '0;
    m_ipc    = '0;
    m_fault  = 1'b0;
    m_faddr  = '0;
    m_count  = '0;
    m_xfer   = 1'b0;
    m2_pc    = WRAP_PC;
    m2_valid = 1'b0;
    m2_ipc   = '0;
  endtask

  // One rising edge of the behavioural model, using the inputs driven for this cycle.
  task automatic model_edge();
    m_xfer = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (!m_fault) begin
      if (bus.redirect_valid && bus.redirect_addr[1:0] != 2'b00) begin
        m_fault = 1'b1;
        m_faddr = bus.redirect_addr;
        m_valid = 1'b0;
      end else if (bus.redirect_valid) begin
        m_pc    = bus.redirect_addr;
        m_valid = 1'b0;
      end else begin
        if (m_valid && bus.if_ready) begin
          m_count = m_count + 1;
          m_xfer  = 1'b1;
        end
        if (!m_valid || bus.if_ready) begin
          m_instr = mem_word(m_pc);
          m_ipc   = m_pc;
          m_valid = 1'b1;
          m_pc    = m_pc + 4;
        end
      end
    end
    m2_ipc   = m2_pc;
    m2_valid = 1'b1;
    m2_pc    = m2_pc + 4;
  endtask

  // Compare every output that is meaningful this cycle against the model.
  task automatic compare_all();
    if (m_xfer) $display("xfer #%0d pc=%h instr=%h", m_count, m_ipc, m_instr);
    check("imem_read_addr", bus.imem_read_addr, m_pc);
    check("if_valid", 32'(bus.if_valid), 32'(m_valid));
    check("misaligned_fault", 32'(bus.misaligned_fault), 32'(m_fault));
    check("fault_addr", bus.fault_addr, m_faddr);
    check("fetch_count", bus.fetch_count, m_count);
    if (m_valid) begin
      check("if_pc", bus.if_pc, m_ipc);
      check("if_instruction", bus.if_instruction, m_instr);
    end
    check("wrap imem_read_addr", bus2.imem_read_addr, m2_pc);
    check("wrap if_valid", 32'(bus2.if_valid), 32'(m2_valid));
    if (m2_valid) check("wrap if_pc", bus2.if_pc, m2_ipc);
  endtask

  // Advance one clock: model the edge, compare just after it, and return at
  // the falling edge, ready for the next inputs.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  initial begin
    rst                = 1'b1;
    bus.if_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = '0;
    model_reset();
    cycle();
    cycle();

    // Reset state.
    check("reset if_valid", 32'(bus.if_valid), 32'd0);
    check("reset if_pc", bus.if_pc, 32'h0);
    check("reset if_instruction", bus.if_instruction, 32'h0);
    check("reset imem_read_addr", bus.imem_read_addr, 32'h0);
    check("reset fetch_count", bus.fetch_count, 32'h0);
    check("reset fault", 32'(bus.misaligned_fault), 32'd0);

    // Reset release with decode always ready.
    rst = 1'b0;
    cycle();
    check("t1 e1 if_valid", 32'(bus.if_valid), 32'd1);
    check("t1 e1 if_pc", bus.if_pc, 32'h0);
    check("t1 e1 instr", bus.if_instruction, 32'h0000_0013);
    check("t5 e1 wrap if_pc", bus2.if_pc, 32'hFFFF_FFFC);
    cycle();
    check("t1 e2 if_pc", bus.if_pc, 32'h4);
    check("t1 e2 instr", bus.if_instruction, 32'h0050_0093);
    check("t5 e2 wrap if_pc", bus2.if_pc, 32'h0000_0000);

    // Three-cycle stall, then resume at the next PC.
    bus.if_ready = 1'b0;
    repeat (3) cycle();
    check("t2 stall if_pc", bus.if_pc, 32'h4);
    check("t2 stall instr", bus.if_instruction, 32'h0050_0093);
    check("t2 stall addr", bus.imem_read_addr, 32'h8);
    check("t2 stall count", bus.fetch_count, 32'd1);
    bus.if_ready = 1'b1;
    cycle();
    check("t2 resume if_pc", bus.if_pc, 32'h8);
    check("t2 resume count", bus.fetch_count, 32'd2);

    // Aligned redirect while stalled.
    bus.if_ready       = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'h40;
    cycle();
    check("t3 flush if_valid", 32'(bus.if_valid), 32'd0);
    check("t3 redirect addr", bus.imem_read_addr, 32'h40);
    check("t3 flush count", bus.fetch_count, 32'd2);
    bus.redirect_valid = 1'b0;
    bus.if_ready       = 1'b1;
    cycle();
    check("t3 target if_pc", bus.if_pc, 32'h40);
    check("t3 target count", bus.fetch_count, 32'd2);

    // Misaligned redirect traps; later redirects are ignored.
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'h42;
    cycle();
    check("t4 fault", 32'(bus.misaligned_fault), 32'd1);
    check("t4 fault_addr", bus.fault_addr, 32'h42);
    check("t4 if_valid", 32'(bus.if_valid), 32'd0);
    bus.redirect_addr = 32'h80;
    cycle();
    check("t4 ignored addr", bus.imem_read_addr, 32'h44);
    check("t4 held fault_addr", bus.fault_addr, 32'h42);
    bus.redirect_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t4 rst clears fault", 32'(bus.misaligned_fault), 32'd0);
    check("t4 rst pc", bus.imem_read_addr, MAIN_PC);
    cycle();
    rst = 1'b0;
    cycle();
    cycle();

    // Asynchronous reset in the middle of a stall.
    bus.if_ready = 1'b0;
    cycle();
    #2;
    rst = 1'b1;
    #1;
    check("t6 async if_valid", 32'(bus.if_valid), 32'd0);
    check("t6 async pc", bus.imem_read_addr, MAIN_PC);
    check("t6 async count", bus.fetch_count, 32'd0);
    check("t6 async if_pc", bus.if_pc, 32'h0);
    cycle();
    rst          = 1'b0;
    bus.if_ready = 1'b1;

    // Randomized traffic: ready gaps, redirects (some misaligned or near the
    // top of the address space), and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      bus.if_ready       = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 9) == 0);
      tgt = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | {28'h0, 2'($urandom_range(0, 3)), 2'b00};
      if ($urandom_range(0, 11) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      bus.redirect_addr = tgt;
      rst = m_fault ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
